// File: rtl/seq_alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared definitions for the seq_alu datapath.
//
// Contents:
//    op_e          : 4-bit operation codes (OP_ADD .. OP_MUL)
//    state_e       : controller states (S_IDLE, S_MUL, S_DONE)
//    OP_LAST_LEGAL : highest opcode this build implements
//
// Configuration macro: SEQ_ALU_MUL_EN
//    defined     -> OP_MUL is a legal (multi-cycle) operation
//    not defined -> OP_MUL is treated like any other illegal opcode
// ---------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_NOT = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4,
      OP_XOR = 4'd5,
      OP_SLT = 4'd6,
      OP_EQ  = 4'd7,
      OP_MUL = 4'd8
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Everything above this code raises err; the multiplier moves the limit.
`ifdef SEQ_ALU_MUL_EN
   localparam op_e OP_LAST_LEGAL = OP_MUL;
`else
   localparam op_e OP_LAST_LEGAL = OP_EQ;
`endif

endpackage

// File: rtl/seq_alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter : iterative shift-add unsigned multiplier.
//
// Ports:
//    clk, rst_n : clock, asynchronous active-low reset
//    start      : load operands a/b and begin; one add step per later edge
//    a, b       : WIDTH-bit unsigned operands
//    done       : high during the cycle whose edge performs the last step
//    product    : 2*WIDTH-bit result, valid while done is high
//
// Takes WIDTH edges after the start edge. The final product is presented
// combinationally in the done cycle so the caller can register it on the
// same edge as the last step.
// ---------------------------------------------------------------------------
module alu_mul_iter #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               busy;

   // The multiplicand is pre-shifted each step, so the partial sum only
   // ever needs the current multiplier LSB.
   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign done     = busy && (cnt == CNT_LAST);
   assign product  = acc_next;

   // Operand capture on start, then one shift-add per edge until the last
   // step; reset throws away any partial product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         acc    <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         acc    <= '0;
         mplier <= b;
         cnt    <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu : handshaked ALU with registered result and flags.
//
// Ports:
//    clk, rst_n          : clock, asynchronous active-low reset
//    in_valid / in_ready : request channel (a, b, op captured on handshake)
//    a, b                : WIDTH-bit operands
//    op                  : 4-bit opcode (alu_pkg::op_e)
//    out_valid/out_ready : response channel; result held until consumed
//    res                 : WIDTH-bit result
//    car, of, zero, neg  : carry / signed overflow / res==0 / res MSB
//    err                 : illegal or compiled-out opcode
//
// Configuration macro: SEQ_ALU_MUL_EN enables the multi-cycle OP_MUL path.
// ---------------------------------------------------------------------------
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             car,
   output logic             of,
   output logic             zero,
   output logic             neg,
   output logic             err
);

   state_e           state;
   state_e           state_nxt;
   op_e              op_sel;
   logic             accept;
   logic             mul_start;
   logic             load_mul;
   logic             load_any;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] sc_res;
   logic             sc_car;
   logic             sc_of;
   logic             sc_err;
   logic [WIDTH-1:0] wr_res;
   logic             wr_car;
   logic             wr_of;
   logic             wr_err;

   assign op_sel    = op_e'(op);
   assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
   assign out_valid = (state == S_DONE);
   assign accept    = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign mul_start = accept && (op_sel == OP_MUL);
   assign load_mul  = (state == S_MUL) && mul_done;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`else
   assign mul_start = 1'b0;
   assign load_mul  = 1'b0;
`endif

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

   // Single-cycle result computed straight from the live inputs; it is only
   // registered on the acceptance edge, which is what freezes the operands.
   always_comb begin
      sc_res = '0;
      sc_car = 1'b0;
      sc_of  = 1'b0;
      sc_err = 1'b0;
      if (op_sel > OP_LAST_LEGAL) begin
         sc_err = 1'b1;
      end else begin
         case (op_sel)
            OP_ADD: begin
               sc_res = sum[WIDTH-1:0];
               sc_car = sum[WIDTH];
               sc_of  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
               sc_res = diff[WIDTH-1:0];
               sc_car = diff[WIDTH];
               sc_of  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  sc_res = ~a;
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
            default: sc_err = 1'b1;
         endcase
      end
   end

   // Pick what gets written into the output registers: a finishing multiply
   // wins, otherwise the single-cycle result of the request being accepted.
   always_comb begin
      wr_res = sc_res;
      wr_car = sc_car;
      wr_of  = sc_of;
      wr_err = sc_err;
`ifdef SEQ_ALU_MUL_EN
      if (load_mul) begin
         wr_res = mul_product[WIDTH-1:0];
         wr_car = |mul_product[2*WIDTH-1:WIDTH];
         wr_of  = 1'b0;
         wr_err = 1'b0;
      end
`endif
   end

   assign load_any = load_mul || (accept && !mul_start);

   // A request accepted from DONE with out_ready takes priority over the
   // plain DONE->IDLE return so back-to-back results lose no cycle.
   always_comb begin
      state_nxt = state;
      if (accept) begin
         state_nxt = mul_start ? S_MUL : S_DONE;
      end else if (load_mul) begin
         state_nxt = S_DONE;
      end else if ((state == S_DONE) && out_ready) begin
         state_nxt = S_IDLE;
      end
   end

   // Output registers only move when a new result is written, so they stay
   // stable under back-pressure and through a multiply in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         res   <= '0;
         car   <= 1'b0;
         of    <= 1'b0;
         zero  <= 1'b1;
         neg   <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_any) begin
            res  <= wr_res;
            car  <= wr_car;
            of   <= wr_of;
            zero <= (wr_res == '0);
            neg  <= wr_res[WIDTH-1];
            err  <= wr_err;
         end
      end
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked ALU for the NPC datapath labs. Successor to the 4-bit combinational ALU: operand width is a parameter, every result and flag is registered, and a multi-cycle shift-add multiply is added. Operands enter through a valid/ready request channel and results leave through a valid/ready response channel. The 7-segment display logic stays outside and consumes `res` when `out_valid` is high.

## Interface
- `WIDTH`, 4: operand and result width, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted this cycle when `in_valid && in_ready`.
- `a`, `b` input WIDTH: operands, two's complement where signed.
- `op` input 4: operation code, see Operation.
- `out_valid` output 1: result valid, held until consumed.
- `out_ready` input 1: consumer accepts the result.
- `res` output WIDTH: result.
- `car` output 1: carry out / multiply high-half nonzero.
- `of` output 1: signed overflow.
- `zero` output 1: `res == 0`.
- `neg` output 1: `res[WIDTH-1]`.
- `err` output 1: illegal or compiled-out opcode.

## Operation
- Opcodes:
  - 0 ADD: `{car,res}=a+b`; `of` set when the signs of a and b are equal and the sign of res differs.
  - 1 SUB: `{car,res}=a+~b+1`; `car`=1 means no borrow; `of` set when the signs of a and b differ and the sign of res differs from a.
  - 2 NOT: `~a`.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SLT: res=1 if a<b signed, else 0.
  - 7 EQ: res=1 if a==b, else 0.
  - 8 MUL: low WIDTH bits of unsigned a*b; `car`=|high half; `of`=0.
- `car` and `of` are 0 for ops 2–7.
- Opcodes 9–15: `res`=0, all flags 0 except `err`=1 and `zero`=1. Single-cycle.
- FSM states:
  - IDLE: accepts a request.
  - MUL: iterating.
  - DONE: result held.
- Transitions:
  - IDLE→DONE on accepting a single-cycle op.
  - IDLE→MUL on accepting MUL.
  - MUL→DONE when the step counter reaches WIDTH-1.
  - DONE→IDLE on `out_ready`. If a new request is accepted in that same cycle, go to DONE or MUL per its op instead.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). Never asserted in MUL.
- `out_valid` = (state==DONE).
- Operands and opcode are captured at acceptance. Later changes to `a`, `b`, `op` do not affect an in-flight operation.
- `res`/flags change only on the cycle a new result is written. They are stable while `out_valid && !out_ready`.

## Timing
- Reset values of all outputs: `in_ready`=1, `out_valid`=0, `res`=0, `car`=`of`=`neg`=`err`=0, `zero`=1. State=IDLE, counter=0.
- Reset is asynchronous and takes effect immediately, including mid-MUL. The partial product is discarded and no result is produced.
- Single-cycle ops: accepted at edge k, `out_valid`=1 after edge k.
- MUL: accepted at edge k, one shift-add step per edge, `out_valid`=1 after edge k+WIDTH.
- Throughput:
  - Single-cycle ops: one result per cycle when `out_ready` is held high.
  - MUL: one per WIDTH+1 cycles.
- Results are never dropped. A request is never accepted while an unconsumed result would be overwritten.

## Configuration
- `SEQ_ALU_MUL_EN` defined: opcode 8 is implemented as above, including the MUL state and iterative multiplier.
- Not defined: the MUL state and multiplier are removed. Opcode 8 is treated as illegal (`err`=1, single-cycle), and `in_ready` depends only on IDLE/DONE.

## Structure
- Package `alu_pkg` holds:
  - the opcode enum (`OP_ADD` … `OP_MUL`, 4 bits);
  - the FSM state enum (`S_IDLE`, `S_MUL`, `S_DONE`);
  - the `OP_LAST_LEGAL` constant.
- Sub-module `alu_mul_iter`: WIDTH-parameterised shift-add multiplier.
  - Interface: `start`, operands, `done`, 2·WIDTH product.
  - Instantiated only under `SEQ_ALU_MUL_EN`.
- Top-level `seq_alu` holds the FSM, the handshake, the single-cycle ops and the flag registers.

## Test plan
All cases at WIDTH=4 unless noted.
- ADD a=7, b=1 → res=8, of=1, car=0, neg=1, zero=0, `out_valid` one cycle after acceptance.
- SUB a=0, b=1 → res=4'hF, car=0, of=0. SUB a=5, b=3 → res=2, car=1.
- SLT a=4'hE (−2), b=1 → res=1. EQ a=9, b=9 → res=1. Opcode 4'hF → res=0, err=1, zero=1.
- MUL a=7, b=3 → res=5, car=1, `out_valid` exactly 4 edges after acceptance, `in_ready`=0 meanwhile. With `SEQ_ALU_MUL_EN` undefined → err=1 after 1 cycle.
- Back-pressure: `out_ready`=0 for 5 cycles after an ADD → res/flags stable, `in_ready`=0. Raising `out_ready` together with a new `in_valid` → new request accepted that cycle, next result one cycle later.
- `rst_n` pulsed low during cycle 2 of a MUL → outputs return to reset values immediately, no `out_valid` follows. The next request behaves normally.
